// File: rtl/decode_pipe.sv
// decode_pipe: DEPTH-stage valid/ready register pipeline with collapsing bubbles,
// synchronous flush and a registered occupancy count.
module decode_pipe #(
  parameter int DATA_W = 34,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
);
  logic [DEPTH-1:0] r_v, w_ld, w_v_nxt;
  logic [DEPTH:0]   w_src_v;
  logic [OCC_W-1:0] r_occ, w_occ_nxt;
  logic             w_hole, w_in_xfer;
  // A stage loads when it or any stage downstream has a hole, or the output drains;
  // this makes in_ready combinationally dependent on out_ready.
  always_comb begin
    w_ld = '0;
    w_hole = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_hole = w_hole | ~r_v[k];
      w_ld[k] = w_hole;
    end
  end
  assign in_ready  = w_ld[0] & ~flush;
  assign w_in_xfer = in_valid & in_ready;
  assign w_src_v   = {r_v, w_in_xfer};
  always_comb begin
    w_v_nxt = r_v;
    w_occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_v_nxt[k] = flush ? 1'b0 : w_ld[k] ? w_src_v[k] : r_v[k];
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[k]);
    end
  end
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_occ <= '0;
    end else begin
      r_v <= w_v_nxt;
      r_occ <= w_occ_nxt;
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DATA_W-1:0] r_d, w_src_d;
    if (k == 0) begin : g_first
      assign w_src_d = in_data;
    end else begin : g_next
      assign w_src_d = g_stage[k-1].r_d;
    end
    always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) r_d <= '0;
      else if (!flush && w_ld[k] && w_src_v[k]) r_d <= w_src_d;
    end
  end
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = g_stage[DEPTH-1].r_d;
  assign occupancy = r_occ;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed DEPTH=3 scenarios plus randomized scoreboard runs
// over DEPTH 3/1/2/8 instances sharing one stimulus.
module tb_decode_pipe;
  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic rst_n, flush, in_valid, out_ready;
  logic [33:0] in_data;
  logic ir[4], ov[4];
  logic [33:0] od[4];
  logic [3:0] oc[4];
  logic [1:0] o3, o2;
  logic [0:0] o1;
  logic [3:0] o8;
  assign oc[0] = {2'b0, o3};
  assign oc[1] = {3'b0, o1};
  assign oc[2] = {2'b0, o2};
  assign oc[3] = o8;

  localparam int DEP [4] = '{3, 1, 2, 8};

  decode_pipe #(.DATA_W(34), .DEPTH(3)) u3 (.clk_2(clk_2), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]), .out_valid(ov[0]),
    .out_data(od[0]), .out_ready(out_ready), .occupancy(o3));
  decode_pipe #(.DATA_W(34), .DEPTH(1)) u1 (.clk_2(clk_2), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]), .out_valid(ov[1]),
    .out_data(od[1]), .out_ready(out_ready), .occupancy(o1));
  decode_pipe #(.DATA_W(34), .DEPTH(2)) u2 (.clk_2(clk_2), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]), .out_valid(ov[2]),
    .out_data(od[2]), .out_ready(out_ready), .occupancy(o2));
  decode_pipe #(.DATA_W(34), .DEPTH(8)) u8 (.clk_2(clk_2), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[3]), .out_valid(ov[3]),
    .out_data(od[3]), .out_ready(out_ready), .occupancy(o8));

  int n_chk = 0;
  int n_pass = 0;

  // Scoreboard: per-instance circular FIFO of words and the cycle each entered.
  logic [33:0] md[4][256];
  int mt[4][256];
  int hd[4], cn[4];

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL rst_ov[%0d] got %b want 0", i, ov[i]); else n_pass++;
      n_chk++; if (oc[i] !== 4'd0) $display("FAIL rst_occ[%0d] got %0d want 0", i, oc[i]); else n_pass++;
      n_chk++; if (od[i] !== 34'd0) $display("FAIL rst_data[%0d] got %h want 0", i, od[i]); else n_pass++;
    end
    @(posedge clk_2); #1 rst_n = 1'b1;
    @(negedge clk_2);
    n_chk++; if (ir[0] !== 1'b1) $display("FAIL rst_in_ready got %b want 1", ir[0]); else n_pass++;
  endtask

  task automatic test_latency();
    @(posedge clk_2); #1;
    in_valid = 1'b1; in_data = 34'h2_AAAA_5555; out_ready = 1'b1;
    @(negedge clk_2);
    n_chk++; if (ir[0] !== 1'b1) $display("FAIL lat_in_ready got %b want 1", ir[0]); else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk_2); #1 in_valid = 1'b0;
      @(negedge clk_2);
      n_chk++; if (ov[0] !== 1'(c == 3)) $display("FAIL lat_ov c%0d got %b want %b", c, ov[0], c == 3); else n_pass++;
      n_chk++; if (oc[0] !== 4'(c <= 3)) $display("FAIL lat_occ c%0d got %0d want %0d", c, oc[0], c <= 3); else n_pass++;
      if (c == 3) begin
        n_chk++; if (od[0] !== 34'h2_AAAA_5555) $display("FAIL lat_data got %h want 2aaaa5555", od[0]); else n_pass++;
      end
    end
  endtask

  task automatic test_stream();
    int nxt = 1;
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk_2); #1;
      in_valid = c < 8; in_data = 34'(c + 1);
      @(negedge clk_2);
      n_chk++; if (ov[0] !== 1'(c >= 3 && c <= 10)) $display("FAIL strm_ov c%0d got %b want %b", c, ov[0], c >= 3 && c <= 10); else n_pass++;
      if (ov[0] === 1'b1) begin
        n_chk++; if (od[0] !== 34'(nxt)) $display("FAIL strm_data c%0d got %h want %h", c, od[0], nxt); else n_pass++;
        nxt++;
      end
    end
    n_chk++; if (nxt != 9) $display("FAIL strm_count got %0d want 8", nxt - 1); else n_pass++;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_2); #1;
      in_valid = 1'b1; in_data = 34'(16 + c);
      @(negedge clk_2);
      n_chk++; if (ir[0] !== 1'(c < 3)) $display("FAIL full_in_ready c%0d got %b want %b", c, ir[0], c < 3); else n_pass++;
    end
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (oc[0] !== 4'd3) $display("FAIL full_occ got %0d want 3", oc[0]); else n_pass++;
      n_chk++; if (ov[0] !== 1'b1 || od[0] !== 34'h10) $display("FAIL full_hold got %b/%h want 1/10", ov[0], od[0]); else n_pass++;
      @(posedge clk_2); #1;
      @(negedge clk_2);
    end
    @(posedge clk_2); #1 out_ready = 1'b1;
    @(negedge clk_2);
    n_chk++; if (ir[0] !== 1'b1) $display("FAIL full_pass_ready got %b want 1", ir[0]); else n_pass++;
    n_chk++; if (od[0] !== 34'h10) $display("FAIL full_pass_data got %h want 10", od[0]); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk_2); #1 in_valid = 1'b0;
      @(negedge clk_2);
      n_chk++; if (ov[0] !== 1'(e < 3)) $display("FAIL drain_ov e%0d got %b want %b", e, ov[0], e < 3); else n_pass++;
      n_chk++; if (oc[0] !== 4'(3 - e)) $display("FAIL drain_occ e%0d got %0d want %0d", e, oc[0], 3 - e); else n_pass++;
      if (e < 3) begin
        n_chk++; if (od[0] !== 34'(17 + e)) $display("FAIL drain_data e%0d got %h want %h", e, od[0], 17 + e); else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_2); #1;
      in_valid = 1'b1; in_data = 34'(32 + c);
    end
    @(posedge clk_2); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 34'h3FF; out_ready = 1'b1;
    @(negedge clk_2);
    n_chk++; if (oc[0] !== 4'd3) $display("FAIL flush_pre_occ got %0d want 3", oc[0]); else n_pass++;
    n_chk++; if (ir[0] !== 1'b0) $display("FAIL flush_in_ready got %b want 0", ir[0]); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_2); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk_2);
      n_chk++; if (ov[0] !== 1'b0) $display("FAIL flush_ov c%0d got %b want 0", c, ov[0]); else n_pass++;
      n_chk++; if (oc[0] !== 4'd0) $display("FAIL flush_occ c%0d got %0d want 0", c, oc[0]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic exp_ir, exp_ov;
    @(posedge clk_2); #1 rst_n = 1'b0;
    @(posedge clk_2); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0; cn[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk_2); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data = {2'($urandom), $urandom};
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk_2);
      for (int i = 0; i < 4; i++) begin
        exp_ir = cn[i] < DEP[i] || out_ready;
        exp_ov = cn[i] > 0 && (cyc - mt[i][hd[i]]) >= DEP[i];
        n_chk++; if (ir[i] !== exp_ir) $display("FAIL rnd_in_ready d%0d cyc%0d got %b want %b", DEP[i], cyc, ir[i], exp_ir); else n_pass++;
        n_chk++; if (ov[i] !== exp_ov) $display("FAIL rnd_ov d%0d cyc%0d got %b want %b", DEP[i], cyc, ov[i], exp_ov); else n_pass++;
        n_chk++; if (oc[i] !== 4'(cn[i])) $display("FAIL rnd_occ d%0d cyc%0d got %0d want %0d", DEP[i], cyc, oc[i], cn[i]); else n_pass++;
        if (exp_ov) begin
          n_chk++; if (od[i] !== md[i][hd[i]]) $display("FAIL rnd_data d%0d cyc%0d got %h want %h", DEP[i], cyc, od[i], md[i][hd[i]]); else n_pass++;
        end
        if (exp_ov && out_ready) begin
          hd[i] = (hd[i] + 1) % 256; cn[i]--;
        end
        if (in_valid && exp_ir) begin
          md[i][(hd[i] + cn[i]) % 256] = in_data;
          mt[i][(hd[i] + cn[i]) % 256] = cyc;
          cn[i]++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_2); #1;
      in_valid = 1'b1; in_data = 34'(c + 100);
    end
    @(posedge clk_2); #2 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL mid_rst_ov d%0d got %b want 0", DEP[i], ov[i]); else n_pass++;
      n_chk++; if (oc[i] !== 4'd0) $display("FAIL mid_rst_occ d%0d got %0d want 0", DEP[i], oc[i]); else n_pass++;
    end
    @(posedge clk_2); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk_2);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ir[i] !== 1'b1) $display("FAIL mid_rst_ready d%0d got %b want 1", DEP[i], ir[i]); else n_pass++;
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL mid_rst_ov_after d%0d got %b want 0", DEP[i], ov[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_full();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 34, payload width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..8.
REQ-003 Port clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk_2 is the integrator's duty.
REQ-005 Port flush  input  1  synchronous clear of all stages, active-high.
REQ-006 Port in_valid  input  1  upstream word present.
REQ-007 Port in_data  input  DATA_W  upstream word.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port out_valid  output  1  output word present.
REQ-010 Port out_data  output  DATA_W  output word.
REQ-011 Port out_ready  input  1  downstream accepts this cycle.
REQ-012 Port occupancy  output  $clog2(DEPTH+1)  number of valid stages, registered.

Function
REQ-013 Block SHALL hold DEPTH stages, each a valid bit v[k] plus data d[k], k=0 input side, k=DEPTH-1 output side.
REQ-014 out_valid SHALL equal v[DEPTH-1]; out_data SHALL equal d[DEPTH-1]; no combinational path from in_data to out_data.
REQ-015 Stage leaves: mv[DEPTH-1] = v[DEPTH-1] & out_ready; mv[k] = v[k] & ld[k+1] for k<DEPTH-1.
REQ-016 Stage loads: ld[k] = !v[k] | mv[k]; bubbles SHALL collapse (an empty stage always loads from its predecessor).
REQ-017 in_ready SHALL equal ld[0] & !flush; combinational dependence on out_ready is permitted and documented.
REQ-018 Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-019 On edge with ld[k]: v[k] <= source valid (in_valid & in_ready for k=0, v[k-1] otherwise); d[k] updated only when source valid is 1.
REQ-020 Latency: word transferred in during cycle t SHALL present out_valid in cycle t+DEPTH when out_ready held high; DEPTH=1 gives one-cycle register behaviour.
REQ-021 Throughput: one word per cycle sustained when out_ready high; order SHALL be preserved, no duplication, no loss.
REQ-022 Stall: while out_valid & !out_ready, out_data and out_valid SHALL remain stable until the transfer.
REQ-023 Full: all v[k]=1 and out_ready=0 SHALL give in_ready=0; simultaneous out transfer and in transfer when full SHALL be allowed (in_ready=1 when out_ready=1).
REQ-024 Empty: all v[k]=0 SHALL give out_valid=0, in_ready=1 (flush=0).
REQ-025 flush=1 SHALL clear all v[k] at the next edge, drop any word in flight, and take precedence over any simultaneous in or out activity; d[k] unchanged.
REQ-026 occupancy SHALL be registered popcount of next-state v, i.e. equal count of valid stages in the following cycle, range 0..DEPTH.
REQ-027 out_data with out_valid=0 is don't-care to consumers but SHALL not contain X after reset.

Reset
REQ-028 rst_n=0 SHALL immediately clear all v[k], d[k] to 0, occupancy to 0, out_valid to 0, regardless of clk_2.
REQ-029 Reset mid-transfer SHALL discard all in-flight words; first cycle after release block is empty with in_ready=1.

Verification
REQ-030 DEPTH=3, DATA_W=34: in_valid one cycle with 34'h2_AAAA_5555, out_ready=1 -> out_valid high exactly 3 cycles later with that value, occupancy 1 then 0.
REQ-031 DEPTH=3: stream 0x1..0x8 back-to-back, out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, starting cycle 3.
REQ-032 DEPTH=3: out_ready=0, push 0x10,0x11,0x12,0x13 -> first three accepted, in_ready=0 on fourth, occupancy 3, out_data stable 0x10; raise out_ready -> 0x13 accepted same cycle 0x10 leaves.
REQ-033 DEPTH=3 full, assert flush with in_valid=1 -> next cycle occupancy 0, out_valid 0, no flushed or concurrent word ever appears at output.
REQ-034 Random in_valid/out_ready (50%), DEPTH in {1,2,8} -> scoreboard shows in-order, lossless delivery and stable out_data during stalls.
REQ-035 Assert rst_n=0 mid-stream between clock edges -> out_valid and occupancy 0 without a clock edge; after release in_ready=1.
